// File: rtl/svm_dot_accum_if.sv
// Beat/result handshake bundle for svm_dot_accum.
// master = the driver/consumer side, slave = the accumulator.
interface svm_dot_accum_if #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_LANES  = 4,
   parameter int ACC_WIDTH  = 40,
   parameter int MAX_BEATS  = 64
);
   localparam int BEATS_WIDTH = $clog2(MAX_BEATS + 1);

   logic                            clr;
   logic                            in_vld;
   logic                            in_rdy;
   logic [NUM_LANES*DATA_WIDTH-1:0] in_data;
   logic                            in_last;
   logic                            out_vld;
   logic                            out_rdy;
   logic signed [ACC_WIDTH-1:0]     out_data;
   logic                            out_ovf;
   logic [BEATS_WIDTH-1:0]          out_beats;

   modport master (
      output clr, in_vld, in_data, in_last, out_rdy,
      input  in_rdy, out_vld, out_data, out_ovf, out_beats
   );

   modport slave (
      input  clr, in_vld, in_data, in_last, out_rdy,
      output in_rdy, out_vld, out_data, out_ovf, out_beats
   );
endinterface

// File: rtl/svm_dot_accum.sv
// Multi-lane signed dot-product accumulator: sums NUM_LANES samples per beat into
// a saturating or wrapping accumulator and presents one result per vector.
module svm_dot_accum #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    NUM_LANES  = 4,
   parameter int                    ACC_WIDTH  = 40,
   parameter int                    MAX_BEATS  = 64,
   parameter int                    SAT_EN     = 1,
   parameter logic signed [ACC_WIDTH-1:0] ACCUM_INIT = '0
) (
   input logic            clk,
   input logic            rst,
   svm_dot_accum_if.slave bus
);
   localparam int BEATS_WIDTH = $clog2(MAX_BEATS + 1);
   localparam int SUM_W       = ACC_WIDTH + 1;
   localparam logic [BEATS_WIDTH-1:0] MAX_CNT = BEATS_WIDTH'(MAX_BEATS);
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                      state;
   logic signed [ACC_WIDTH-1:0] acc;
   logic [BEATS_WIDTH-1:0]      count;
   logic                        ovf;
   logic                        in_rdy_q;
   logic                        out_vld_q;

   logic signed [SUM_W-1:0]     lane_sum;
   logic signed [SUM_W-1:0]     acc_sum;
   logic signed [ACC_WIDTH-1:0] acc_next;
   logic [BEATS_WIDTH-1:0]      count_inc;
   logic                        ovf_now;
   logic                        beat;
   logic                        term;

   // The extra sum bit differs from the sign bit exactly when the result left range.
   function automatic logic signed [ACC_WIDTH-1:0] fit_acc(input logic signed [SUM_W-1:0] s);
      if (s[SUM_W-1] == s[SUM_W-2]) begin
         fit_acc = s[ACC_WIDTH-1:0];
      end else if (SAT_EN == 0) begin
         fit_acc = s[ACC_WIDTH-1:0];
      end else if (s[SUM_W-1]) begin
         fit_acc = ACC_MIN;
      end else begin
         fit_acc = ACC_MAX;
      end
   endfunction

   // Sign-extended sum of every lane of the current beat
   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_sum = lane_sum + SUM_W'($signed(bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]));
      end
   end

   // Next accumulator value, overflow flag and vector-termination decode
   always_comb begin
      acc_sum   = SUM_W'(acc) + lane_sum;
      acc_next  = fit_acc(acc_sum);
      ovf_now   = acc_sum[SUM_W-1] ^ acc_sum[SUM_W-2];
      count_inc = count + BEATS_WIDTH'(1);
      beat      = bus.in_vld && in_rdy_q;
      term      = bus.in_last || (count_inc == MAX_CNT);
   end

   // Control FSM with registered handshakes; clr outranks the result handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= ACCUM_INIT;
         count     <= '0;
         ovf       <= 1'b0;
         in_rdy_q  <= 1'b1;
         out_vld_q <= 1'b0;
      end else if (bus.clr) begin
         state     <= IDLE;
         acc       <= ACCUM_INIT;
         count     <= '0;
         ovf       <= 1'b0;
         in_rdy_q  <= 1'b1;
         out_vld_q <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (beat) begin
                  acc   <= acc_next;
                  count <= count_inc;
                  ovf   <= ovf | ovf_now;
                  if (term) begin
                     state     <= HOLD;
                     in_rdy_q  <= 1'b0;
                     out_vld_q <= 1'b1;
                  end else begin
                     state <= ACCUM;
                  end
               end else begin
                  state <= state;
               end
            end
            HOLD: begin
               if (bus.out_rdy) begin
                  state     <= IDLE;
                  acc       <= ACCUM_INIT;
                  count     <= '0;
                  ovf       <= 1'b0;
                  in_rdy_q  <= 1'b1;
                  out_vld_q <= 1'b0;
               end else begin
                  state <= HOLD;
               end
            end
            default: begin
               state     <= IDLE;
               acc       <= ACCUM_INIT;
               count     <= '0;
               ovf       <= 1'b0;
               in_rdy_q  <= 1'b1;
               out_vld_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_rdy    = in_rdy_q;
   assign bus.out_vld   = out_vld_q;
   assign bus.out_data  = acc;
   assign bus.out_ovf   = ovf;
   assign bus.out_beats = count;
endmodule
